// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, response record and constants for the APB manager.
package apb_pkg;
    localparam int APB_DATA_W = 32;
    localparam int APB_NO_TIMEOUT = 0;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_resp_t;
endpackage

// File: rtl/apb_if.sv
// apb_if: command/response stream plus APB bus signals between requester, manager and subordinate.
interface apb_if #(parameter int AddrWidth = 32, parameter int DataWidth = 32);
    logic                 reqValid, reqReady, reqWrite;
    logic [AddrWidth-1:0] reqAddr;
    logic [DataWidth-1:0] reqWData;
    logic                 respValid, respReady, respErr, respTimeout;
    logic [DataWidth-1:0] respRData;
    logic                 sel, enable, write, readyOut, subErr;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wData, rData;
    modport master (
        input  reqValid, reqAddr, reqWData, reqWrite, respReady, rData, readyOut, subErr,
        output reqReady, respValid, respRData, respErr, respTimeout, sel, enable, addr, wData, write
    );
    modport slave (
        output reqValid, reqAddr, reqWData, reqWrite, respReady, rData, readyOut, subErr,
        input  reqReady, respValid, respRData, respErr, respTimeout, sel, enable, addr, wData, write
    );
endinterface

// File: rtl/apb_watchdog.sv
// apb_watchdog: loadable down-counter flagging the last permitted ACCESS wait cycle.
module apb_watchdog #(
    parameter int TimeoutCycles = 1
) (
    input  logic clk,
    input  logic nReset,
    input  logic start,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TimeoutCycles + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) cnt <= '0;
        else if (start) cnt <= CW'(TimeoutCycles - 1);
        else if (tick && cnt != '0) cnt <= cnt - 1'b1;
    assign expired = cnt == '0;
endmodule

// File: rtl/apb_manager.sv
// apb_manager: turns a valid/ready command stream into APB SETUP/ACCESS transfers with registered responses.
module apb_manager
    import apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = APB_NO_TIMEOUT
) (
    input logic   clk,
    input logic   nReset,
    apb_if.master bus
);
    apb_state_e           state_q, state_d;
    apb_resp_t            resp_q, resp_d;
    logic                 resp_valid_q, write_q, wd_expired, req_fire, done, tmo;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;

    assign bus.reqReady = state_q == IDLE && (!resp_valid_q || bus.respReady);
    assign req_fire     = bus.reqValid && bus.reqReady;
    assign done         = state_q == ACCESS && bus.readyOut;
    assign tmo          = state_q == ACCESS && !bus.readyOut && wd_expired;

    if (TimeoutCycles != APB_NO_TIMEOUT) begin : g_wd
        apb_watchdog #(.TimeoutCycles(TimeoutCycles)) u_wd (
            .clk     (clk),
            .nReset  (nReset),
            .start   (state_q == SETUP),
            .tick    (state_q == ACCESS && !bus.readyOut),
            .expired (wd_expired)
        );
    end else begin : g_no_wd
        assign wd_expired = 1'b0;
    end

    always_comb begin
        state_d        = req_fire ? SETUP : state_q == SETUP ? ACCESS : (done || tmo) ? IDLE : state_q;
        resp_d.rdata   = (tmo || write_q) ? '0 : APB_DATA_W'(bus.rData);
        resp_d.err     = tmo || bus.subErr;
        resp_d.timeout = tmo;
    end

    always_ff @(posedge clk or negedge nReset)
        if (!nReset) begin
            state_q      <= IDLE;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q  <= bus.reqAddr;
                wdata_q <= bus.reqWData;
                write_q <= bus.reqWrite;
            end
            // a completion can only land once the previous response has been taken
            if (done || tmo) begin
                resp_valid_q <= 1'b1;
                resp_q       <= resp_d;
            end else if (bus.respReady) resp_valid_q <= 1'b0;
        end

    assign bus.sel         = state_q != IDLE;
    assign bus.enable      = state_q == ACCESS;
    assign bus.addr        = addr_q;
    assign bus.wData       = wdata_q;
    assign bus.write       = write_q;
    assign bus.respValid   = resp_valid_q;
    assign bus.respRData   = DataWidth'(resp_q.rdata);
    assign bus.respErr     = resp_q.err;
    assign bus.respTimeout = resp_q.timeout;
endmodule

// File: tb/tb_apb_manager.sv
// tb_apb_manager: directed and randomized transfers checked against a transaction-level expectation model.
module tb_apb_manager;
    localparam int T = 4;
    logic clk = 1'b0;
    logic nReset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] cur_addr, cur_wdata, exp_rdata;
    logic cur_write, exp_err, exp_to, had_resp;

    apb_if #(.AddrWidth(32), .DataWidth(32)) bus ();
    apb_manager #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(T)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_bus();
        chk("idle_sel", bus.sel, 0);
        chk("idle_enable", bus.enable, 0);
    endtask

    task automatic chk_resp(input string tag);
        chk({tag, "_valid"}, bus.respValid, 1);
        chk({tag, "_rdata"}, bus.respRData, exp_rdata);
        chk({tag, "_err"}, bus.respErr, exp_err);
        chk({tag, "_timeout"}, bus.respTimeout, exp_to);
    endtask

    task automatic chk_bus(input string tag, input logic en);
        chk({tag, "_sel"}, bus.sel, 1);
        chk({tag, "_enable"}, bus.enable, en);
        chk({tag, "_addr"}, bus.addr, cur_addr);
        chk({tag, "_wdata"}, bus.wData, cur_wdata);
        chk({tag, "_write"}, bus.write, cur_write);
        chk({tag, "_resp_valid"}, bus.respValid, 0);
        chk({tag, "_req_ready"}, bus.reqReady, 0);
    endtask

    // One transfer: optional back-pressure on the pending response, then the request,
    // then `waits` low-readyOut ACCESS cycles before the completing one.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic wr, input int waits,
                        input logic [31:0] rd, input logic err, input int stall);
        int n;
        logic timed_out;
        n = (waits >= T) ? T : waits + 1;
        timed_out = waits >= T;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqAddr = a;
        bus.reqWData = d;
        bus.reqWrite = wr;
        bus.respReady = 1'b0;
        for (int s = 0; had_resp && s < stall; s++) begin
            #1;
            chk("bp_req_ready", bus.reqReady, 0);
            chk_resp("bp_resp");
            chk_idle_bus();
            chk("bp_addr_hold", bus.addr, cur_addr);
            @(negedge clk);
        end
        bus.respReady = 1'b1;
        #1;
        chk("req_ready", bus.reqReady, 1);
        @(negedge clk);
        cur_addr = a;
        cur_wdata = d;
        cur_write = wr;
        bus.reqValid = 1'($urandom);
        bus.reqAddr = $urandom;
        bus.reqWData = $urandom;
        bus.reqWrite = 1'($urandom);
        bus.respReady = 1'($urandom);
        chk_bus("setup", 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_bus("access", 1);
            bus.readyOut = (i == waits);
            bus.rData = (i == waits) ? rd : $urandom;
            bus.subErr = (i == waits) ? err : 1'($urandom);
        end
        @(negedge clk);
        bus.readyOut = 1'b0;
        bus.reqValid = 1'b0;
        bus.respReady = 1'b0;
        exp_rdata = (timed_out || wr) ? 32'h0 : rd;
        exp_err = timed_out || err;
        exp_to = timed_out;
        had_resp = 1'b1;
        chk_idle_bus();
        chk_resp("done");
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqAddr = 32'h55;
        bus.reqWData = 32'hAA;
        bus.reqWrite = 1'b1;
        bus.respReady = 1'b1;
        bus.readyOut = 1'b0;
        repeat (3) @(negedge clk) bus.reqValid = 1'b0;
        chk("rst_pre_enable", bus.enable, 1);
        #2 nReset = 1'b0;
        #1;
        chk_idle_bus();
        chk("rst_resp_valid", bus.respValid, 0);
        chk("rst_addr", bus.addr, 0);
        @(negedge clk);
        nReset = 1'b1;
        had_resp = 1'b0;
        cur_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_no_resp", bus.respValid, 0);
        chk_idle_bus();
    endtask

    initial begin
        bus.reqValid = 0; bus.reqAddr = 0; bus.reqWData = 0; bus.reqWrite = 0;
        bus.respReady = 0; bus.rData = 0; bus.readyOut = 0; bus.subErr = 0;
        had_resp = 0; cur_addr = 0; cur_wdata = 0; cur_write = 0;
        exp_rdata = 0; exp_err = 0; exp_to = 0;
        repeat (2) @(negedge clk);
        chk_idle_bus();
        chk("rst_write", bus.write, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wData, 0);
        chk("rst_resp_valid", bus.respValid, 0);
        chk("rst_resp_rdata", bus.respRData, 0);
        chk("rst_resp_err", bus.respErr, 0);
        chk("rst_resp_timeout", bus.respTimeout, 0);
        nReset = 1'b1;
        #1 chk("rst_req_ready", bus.reqReady, 1);
        xfer(32'h4, 32'h0000_00FF, 1'b1, 0, 32'h1234_5678, 1'b0, 0);
        xfer(32'h10, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(32'h8, 32'h0, 1'b0, 0, 32'hCAFE_0001, 1'b1, 0);
        xfer(32'h20, 32'h0, 1'b0, 10, 32'h7777_7777, 1'b0, 0);
        xfer(32'h30, 32'h1234, 1'b1, 1, 32'h0, 1'b0, 5);
        reset_mid();
        xfer(32'h40, 32'h9999_0000, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 0);
        for (int k = 0; k < 40; k++)
            xfer($urandom, $urandom, 1'($urandom), $urandom_range(0, 6), $urandom,
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        @(negedge clk);
        bus.respReady = 1'b1;
        @(negedge clk);
        chk("final_drain", bus.respValid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_manager.md
Name: apb_manager

Overview:
- APB manager (requester) stage that sits directly upstream of APB subordinates such as the GPIO block and drives their sel/enable/addr/wData/write.
- Converts a simple valid/ready command stream into compliant SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Has an optional wait-state watchdog so a hung subordinate cannot stall the system forever.

Parameters:
- AddrWidth, 32, width of request address and APB addr.
- DataWidth, 32, width of write/read data.
- TimeoutCycles, 0, maximum ACCESS cycles with readyOut low before the transfer is abandoned; 0 disables the watchdog.

Ports:
- clk  in  1  system clock (PCLK).
- nReset  in  1  reset; asynchronous, active-low.
- reqValid  in  1  command valid.
- reqReady  out  1  command accepted when reqValid&&reqReady at clk rise.
- reqAddr  in  AddrWidth  command address.
- reqWData  in  DataWidth  command write data.
- reqWrite  in  1  1=write, 0=read.
- respValid  out  1  response valid.
- respReady  in  1  response consumed when respValid&&respReady.
- respRData  out  DataWidth  read data; 0 for writes.
- respErr  out  1  subErr sampled at completion, or watchdog expiry.
- respTimeout  out  1  transfer ended by watchdog.
- sel  out  1  PSEL.
- enable  out  1  PENABLE.
- addr  out  AddrWidth  PADDR.
- wData  out  DataWidth  PWDATA.
- write  out  1  PWRITE.
- rData  in  DataWidth  PRDATA.
- readyOut  in  1  PREADY.
- subErr  in  1  PSLVERR.

Behaviour:
- Reset (async, nReset=0): state=IDLE.
  - sel, enable, write = 0.
  - addr, wData = 0.
  - respValid, respRData, respErr, respTimeout = 0.
  - Watchdog count = 0.
  - A transfer in flight is dropped and produces no response.
- reqReady is combinational: (state==IDLE) && (!respValid || respReady). It is low throughout SETUP and ACCESS.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on request handshake.
    - addr, wData, write register from reqAddr, reqWData, reqWrite.
    - sel=1, enable=0 next cycle.
  - SETUP -> ACCESS unconditionally after 1 cycle; enable=1.
  - ACCESS, readyOut=1 -> IDLE.
    - sel=0, enable=0.
    - respValid=1.
    - respRData = write ? 0 : rData.
    - respErr = subErr.
    - respTimeout = 0.
  - ACCESS, readyOut=0 -> stay in ACCESS.
    - sel, enable, addr, wData, write held stable.
    - Watchdog count increments.
  - ACCESS, watchdog expiry (TimeoutCycles!=0, readyOut=0, count==TimeoutCycles-1) -> IDLE.
    - sel=0, enable=0.
    - respValid=1, respErr=1, respTimeout=1, respRData=0.
- Watchdog count clears on entry to ACCESS.
- addr, wData and write keep their last value after a transfer; they change only on a new handshake.
- Latency: handshake at edge 0 -> SETUP in cycle 1 -> ACCESS in cycle 2. With zero wait states, respValid is high in cycle 3. Each wait state adds 1 cycle.
- Minimum spacing between transfers is 3 cycles.
- Response register:
  - Holds respValid/data/flags stable until respReady.
  - respValid clears on the handshake unless a new completion loads in the same cycle.
  - Only one outstanding response is allowed; that is guaranteed by the reqReady gating.
- Simultaneous respReady and reqValid in IDLE with respValid=1: both handshakes occur in the same cycle.
- reqValid is ignored outside IDLE; requester stimulus is not sampled after acceptance.
- No combinational path from rData, readyOut or subErr to any output; responses are registered.

Decomposition:
- Package apb_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}.
  - typedef struct apb_resp_t {rData, err, timeout}, parameterised via localparam widths.
  - Constant APB_NO_TIMEOUT = 0.
- One sub-module is natural: apb_watchdog.
  - Loadable down-counter of width $clog2(TimeoutCycles+1).
  - Ports: clk, nReset, start, tick, expired.
  - Tied off when TimeoutCycles=0.
- The remaining FSM and registers stay in apb_manager.

Test Plan:
1. Reset then write: req {addr=0x4, wData=0x0000_00FF, write=1}, subordinate readyOut=1 -> sel high cycle 1, enable cycle 2 with addr=0x4, wData=0xFF; respValid cycle 3, respErr=0, respRData=0.
2. Read with 2 wait states: subordinate returns rData=0xDEAD_BEEF on 3rd ACCESS cycle -> addr/sel/enable stable for 3 ACCESS cycles; respRData=0xDEAD_BEEF in cycle 5.
3. Error: subErr=1 with readyOut=1 on a read of addr=0x8 -> respErr=1, respTimeout=0, FSM back to IDLE.
4. Watchdog: TimeoutCycles=4, readyOut held 0 -> sel/enable drop after 4 ACCESS cycles; respErr=1, respTimeout=1, respRData=0.
5. Back-pressure: respReady=0 for 5 cycles after a completion with reqValid=1 -> reqReady=0 and response stable. When respReady rises, both handshakes happen the same cycle and the next SETUP starts the following cycle.
6. Reset mid-ACCESS: nReset low during a wait-stated transfer -> sel, enable, respValid go 0 immediately without a clock edge; no response after reset release; next request completes normally.
